// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array and its result drain.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } drain_state_t;

    // Cycles from start until the last partial product has settled.
    function automatic int default_lat(input int arow, input int acol, input int bcol);
        return arow + acol + bcol - 1;
    endfunction

    // Index width with a floor of one bit so degenerate 1-wide dimensions still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a sign-extended value into the signed n-bit range; result stays sign-extended.
    function automatic longint sat_to_n(input longint v, input int n);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (n - 1)) - 64'sd1;
        lo = -(longint'(1) <<< (n - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Valid/ready element stream leaving the drain: data plus its row/col coordinates.
interface systolic_drain_if
    import systolic_pkg::*;
#(
    parameter int N    = 16,
    parameter int AROW = 3,
    parameter int BCOL = 3
);
    localparam int RW = idx_w(AROW);
    localparam int CW = idx_w(BCOL);

    logic [2*N-1:0] out_data;
    logic [RW-1:0]  out_row;
    logic [CW-1:0]  out_col;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (output out_data, out_row, out_col, out_valid, out_last,
                    input  out_ready);
    modport slave  (input  out_data, out_row, out_col, out_valid, out_last,
                    output out_ready);
endinterface

// File: rtl/drain_index_counter.sv
// Row-major row/col walker with wrap; last flags the final coordinate of the tile.
module drain_index_counter
    import systolic_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    localparam int RW  = idx_w(ROWS),
    localparam int CW  = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_end, col_end;

    assign row_end = (row_q == RW'(ROWS - 1));
    assign col_end = (col_q == CW'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end && col_end;

endmodule

// File: rtl/systolic_drain.sv
// Waits out the array latency, snapshots the accumulators and streams them row-major.
// Optional SAT_OUT_EN: shift right by SAT_SHIFT and saturate each element to signed N bits.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int N    = 16,
    parameter int AROW = 3,
    parameter int BCOL = 3,
    parameter int ACOL = 3,
    parameter int LAT  = default_lat(AROW, ACOL, BCOL)
`ifdef SAT_OUT_EN
    , parameter int SAT_SHIFT = 0
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [AROW-1:0][BCOL-1:0][2*N-1:0] sys_array,
    systolic_drain_if.master                   out_if,
    output logic                               busy,
    output logic                               done,
    output logic                               array_clr
);
    localparam int DW = 2 * N;
    localparam int RW = idx_w(AROW);
    localparam int CW = idx_w(BCOL);
    localparam int WW = idx_w(LAT);

    drain_state_t                     state_q, state_d;
    logic [WW-1:0]                    wait_cnt_q, wait_cnt_d;
    logic [AROW-1:0][BCOL-1:0][DW-1:0] snap_q, snap_d;
    logic                             array_clr_q, array_clr_d;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
    logic          hs;
    logic [DW-1:0] elem;

    assign hs = out_if.out_valid && out_if.out_ready;

    drain_index_counter #(
        .ROWS (AROW),
        .COLS (BCOL)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == CAPTURE),
        .en   (hs),
        .row  (row),
        .col  (col),
        .last (last)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        snap_d      = snap_q;
        array_clr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WW'(LAT - 1)) state_d = CAPTURE;
                else                            wait_cnt_d = wait_cnt_q + WW'(1);
            end
            CAPTURE: begin
                snap_d      = sys_array;
                array_clr_d = 1'b1;
                state_d     = STREAM;
            end
            STREAM: begin
                if (hs && last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            snap_q      <= '0;
            array_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            snap_q      <= snap_d;
            array_clr_q <= array_clr_d;
        end
    end

    // Read side is a pure mux of the frozen snapshot, so stalls cannot disturb the element.
    assign elem = snap_q[row][col];

`ifdef SAT_OUT_EN
    assign out_if.out_data = DW'(sat_to_n(longint'($signed(elem)) >>> SAT_SHIFT, N));
`else
    assign out_if.out_data = elem;
`endif

    assign out_if.out_row   = row;
    assign out_if.out_col   = col;
    assign out_if.out_valid = (state_q == STREAM);
    assign out_if.out_last  = (state_q == STREAM) && last;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign array_clr = array_clr_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: expected elements queued at start, checked on handshake.
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int N    = 16;
    localparam int AROW = 3;
    localparam int BCOL = 3;
    localparam int ACOL = 3;
    localparam int LAT  = 8;
    localparam int DW   = 2 * N;
    localparam int RW   = idx_w(AROW);
    localparam int CW   = idx_w(BCOL);
    localparam int SMAX = (1 << (N - 1)) - 1;
    localparam int SMIN = -(1 << (N - 1));

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [AROW-1:0][BCOL-1:0][DW-1:0] sys_array;
    logic busy, done, array_clr;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    systolic_drain_if #(.N(N), .AROW(AROW), .BCOL(BCOL)) dif ();

    systolic_drain #(
        .N(N), .AROW(AROW), .BCOL(BCOL), .ACOL(ACOL), .LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sys_array (sys_array),
        .out_if    (dif),
        .busy      (busy),
        .done      (done),
        .array_clr (array_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input logic [DW-1:0] v);
`ifdef SAT_OUT_EN
        if ($signed(v) > SMAX) return DW'(SMAX);
        if ($signed(v) < SMIN) return DW'(SMIN);
`endif
        return v;
    endfunction

    task automatic push_exp();
        exp_t e;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) begin
                e.data = model(sys_array[r][c]);
                e.row  = RW'(r);
                e.col  = CW'(c);
                e.last = (r == AROW - 1) && (c == BCOL - 1);
                exp_q.push_back(e);
            end
    endtask

    task automatic kick(input bit check_busy);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (check_busy) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_rise: got %b want 1", busy);
            end
        end
    endtask

    // lat = clock edges after the start edge until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (dif.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            vectors++; miscompares++;
            $display("FAIL valid_timeout: no out_valid within %0d cycles", lat);
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int max_hs, input int inject_at, output int hs_cnt);
        logic [DW-1:0] pd;
        logic [RW-1:0] pr;
        logic [CW-1:0] pc;
        logic          pl;
        bit            stalled;
        exp_t          e;
        int            cyc;
        stalled = 0; cyc = 0; hs_cnt = 0;
        pd = '0; pr = '0; pc = '0; pl = 1'b0;
        while (exp_q.size() > 0 && hs_cnt < max_hs && cyc < 500) begin
            dif.out_ready = (mode == 0) || (cyc % 3 == 0);
            start = (cyc == inject_at);
            if (cyc > 0) begin
                vectors++;
                if (array_clr !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clr_extra: got %b want 0 at stream cycle %0d", array_clr, cyc);
                end
            end
            vectors++;
            if (dif.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL valid_drop: got %b want 1 at stream cycle %0d", dif.out_valid, cyc);
                cyc = 500;
            end else begin
                if (stalled) begin
                    vectors++;
                    if ({dif.out_data, dif.out_row, dif.out_col, dif.out_last} !== {pd, pr, pc, pl}) begin
                        miscompares++;
                        $display("FAIL stall_hold: got %h r%0d c%0d l%b want %h r%0d c%0d l%b",
                                 dif.out_data, dif.out_row, dif.out_col, dif.out_last, pd, pr, pc, pl);
                    end
                end
                if (dif.out_ready) begin
                    e = exp_q.pop_front();
                    vectors++;
                    if (dif.out_data !== e.data || dif.out_row !== e.row ||
                        dif.out_col !== e.col || dif.out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL elem%0d: got %h r%0d c%0d l%b want %h r%0d c%0d l%b", hs_cnt,
                                 dif.out_data, dif.out_row, dif.out_col, dif.out_last,
                                 e.data, e.row, e.col, e.last);
                    end
                    hs_cnt++;
                end
                stalled = !dif.out_ready;
                pd = dif.out_data; pr = dif.out_row; pc = dif.out_col; pl = dif.out_last;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        dif.out_ready = 1'b1;
    endtask

    task automatic check_done(input bit poke);
        vectors++;
        if (done !== 1'b1 || dif.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b valid=%b want done=1 valid=0", done, dif.out_valid);
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_clear: got done=%b busy=%b want 0 0", done, busy);
        end
        if (poke) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL start_in_done: got busy=%b want 0", busy);
            end
        end
    endtask

    task automatic quiet_watch(input int cycles, input string name);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || dif.out_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d cycles with done/valid high want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'(32'h5A5A_0000 + r * 16 + c);
        rst = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        vectors++;
        if (dif.out_valid !== 1'b0 || dif.out_last !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || array_clr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got v%b l%b b%b d%b c%b want all 0",
                     dif.out_valid, dif.out_last, busy, done, array_clr);
        end
        vectors++;
        if (dif.out_data !== '0 || dif.out_row !== '0 || dif.out_col !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h r%0d c%0d want 0 0 0", dif.out_data, dif.out_row, dif.out_col);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat, hs;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'(10 * r + c);
        push_exp();
        dif.out_ready = 1'b1;
        kick(1);
        wait_valid(lat);
        vectors++;
        if (lat !== LAT + 1) begin
            miscompares++;
            $display("FAIL first_valid_latency: got %0d want %0d", lat, LAT + 1);
        end
        vectors++;
        if (array_clr !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_pulse: got %b want 1 in first stream cycle", array_clr);
        end
        drain(0, 1000, -1, hs);
        check_done(0);
    endtask

    task automatic test_backpressure();
        int lat, hs;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'($urandom_range(0, 30000));
        push_exp();
        kick(0);
        wait_valid(lat);
        drain(1, 1000, -1, hs);
        vectors++;
        if (hs !== AROW * BCOL || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d handshakes want %0d", hs, AROW * BCOL);
        end
        check_done(0);
    endtask

    task automatic test_snapshot();
        int lat, hs;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'(1000 + 7 * r + 3 * c);
        push_exp();
        kick(0);
        wait_valid(lat);
        sys_array = '1;
        drain(0, 1000, -1, hs);
        check_done(0);
    endtask

    task automatic test_reset_mid_stream();
        int lat, hs;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'(200 + 10 * r + c);
        push_exp();
        kick(0);
        wait_valid(lat);
        drain(0, 4, -1, hs);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (dif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            dif.out_row !== '0 || dif.out_col !== '0) begin
            miscompares++;
            $display("FAIL abort: got v%b b%b d%b r%0d c%0d want 0 0 0 0 0",
                     dif.out_valid, busy, done, dif.out_row, dif.out_col);
        end
        rst = 1'b0;
        quiet_watch(12, "abort_quiet");
        exp_q.delete();
        push_exp();
        kick(0);
        wait_valid(lat);
        drain(0, 1000, -1, hs);
        check_done(0);
    endtask

    task automatic test_start_while_busy();
        int lat, hs;
        for (int r = 0; r < AROW; r++)
            for (int c = 0; c < BCOL; c++) sys_array[r][c] = DW'(300 + 5 * r + 2 * c);
        push_exp();
        kick(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_valid(lat);
        drain(0, 1000, 2, hs);
        check_done(1);
        quiet_watch(20, "single_stream");
    endtask

`ifdef SAT_OUT_EN
    task automatic test_sat();
        int lat, hs;
        logic [DW-1:0] vals [9];
        vals = '{32'h0001_0000, 32'hFFFE_0000, 32'h0000_1234,
                 32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000,
                 32'hFFFF_7FFF, 32'h7FFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 9; i++) sys_array[i / 3][i % 3] = vals[i];
        push_exp();
        kick(0);
        wait_valid(lat);
        drain(0, 1000, -1, hs);
        check_done(0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sys_array = '0;
        dif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_reset_mid_stream();
        test_start_while_busy();
`ifdef SAT_OUT_EN
        test_sat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
